truth_table_sweeper: RTL and testbench

- Sequencer for one 4-input combinational function under test, implemented twice (for example a NAND-NAND form and a NOR-NOR form).
- Drives all 16 input vectors in order and waits a programmable settle time on each vector.
- Captures both implementations' outputs into 16-bit truth tables and compares each against an expected table latched at start.
- Sits between a lab top-level or test harness and the gate-level function blocks; reports per-vector mismatch masks and a pass flag.

---
 rtl/truth_table_sweeper_pkg.sv | 17 +
 rtl/truth_table_sweeper_settle_counter.sv | 34 +++
 rtl/truth_table_sweeper.sv | 135 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants and state encoding for the 4-input truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int NUM_VARS = 4;
  localparam int NUM_VECT = 16;

  // f = x1'x2x4' + x1x2 + x3'x4, bit i = f(x=i)
  localparam logic [NUM_VECT-1:0] F_SOP = 16'hF272;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle-time counter: clears on load, counts while enabled, flags SETTLE-1.
module truth_table_sweeper_settle_counter #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == 4'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input vectors, captures two implementations' outputs and
// compares both truth tables against a reference latched at start.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_VECT-1:0] expected,
  input  logic                eval_a,
  input  logic                eval_b,
  output logic [NUM_VARS-1:0] x,
  output logic                busy,
  output logic                done,
  output logic [NUM_VECT-1:0] table_a,
  output logic [NUM_VECT-1:0] table_b,
  output logic [NUM_VECT-1:0] mismatch_a,
  output logic [NUM_VECT-1:0] mismatch_b,
  output logic                pass
);

  state_t              state_q, state_d;
  logic [NUM_VARS-1:0] x_q, x_d;
  logic [NUM_VECT-1:0] expected_q, expected_d;
  logic [NUM_VECT-1:0] table_a_q, table_a_d;
  logic [NUM_VECT-1:0] table_b_q, table_b_d;
  logic [NUM_VECT-1:0] mis_a_q, mis_a_d;
  logic [NUM_VECT-1:0] mis_b_q, mis_b_d;
  logic                pass_q, pass_d;
  logic                cnt_clear, cnt_en, settle_done;
  logic                launch;

  truth_table_sweeper_settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (settle_done)
  );

  // A start from DONE restarts exactly like a start from IDLE.
  assign launch = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    expected_d = expected_q;
    table_a_d  = table_a_q;
    table_b_d  = table_b_q;
    mis_a_d    = mis_a_q;
    mis_b_d    = mis_b_q;
    pass_d     = pass_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (settle_done) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          table_a_d[x_q] = eval_a;
          table_b_d[x_q] = eval_b;
          if (x_q == '1) begin
            state_d = DONE;
            // Compare against the tables including this final capture.
            mis_a_d = table_a_d ^ expected_q;
            mis_b_d = table_b_d ^ expected_q;
            pass_d  = (mis_a_d == '0) && (mis_b_d == '0);
          end else begin
            x_d       = x_q + 4'd1;
            cnt_clear = 1'b1;
            state_d   = DRIVE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d    = DRIVE;
      x_d        = '0;
      cnt_clear  = 1'b1;
      expected_d = expected;
      table_a_d  = '0;
      table_b_d  = '0;
      mis_a_d    = '0;
      mis_b_d    = '0;
      pass_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      expected_q <= '0;
      table_a_q  <= '0;
      table_b_q  <= '0;
      mis_a_q    <= '0;
      mis_b_q    <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      expected_q <= expected_d;
      table_a_q  <= table_a_d;
      table_b_q  <= table_b_d;
      mis_a_q    <= mis_a_d;
      mis_b_q    <= mis_b_d;
      pass_q     <= pass_d;
    end
  end

  assign x          = x_q;
  assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign table_a    = table_a_q;
  assign table_b    = table_b_q;
  assign mismatch_a = mis_a_q;
  assign mismatch_b = mis_b_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper (SETTLE=2 and SETTLE=1 instances).
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Behavioural models of the two implementations: f itself, or an arbitrary table
  logic        sel_a, sel_b;
  logic [15:0] rnd_a, rnd_b;

  logic        start1, abort1, ea1, eb1, busy1, done1, pass1;
  logic [15:0] exp1, ta1, tb1, ma1, mb1;
  logic [3:0]  x1;
  logic        start2, abort2, ea2, eb2, busy2, done2, pass2;
  logic [15:0] exp2, ta2, tb2, ma2, mb2;
  logic [3:0]  x2;

  int checks = 0;
  int failures = 0;

  function automatic logic f_ref(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (!a && b && !d) || (a && b) || (!c && d);
  endfunction

  function automatic logic [15:0] ref_table(input logic sel, input logic [15:0] rnd);
    logic [15:0] t;
    if (sel) return rnd;
    for (int i = 0; i < 16; i++) t[i] = f_ref(4'(i));
    return t;
  endfunction

  assign ea1 = sel_a ? rnd_a[x1] : f_ref(x1);
  assign eb1 = sel_b ? rnd_b[x1] : f_ref(x1);
  assign ea2 = sel_a ? rnd_a[x2] : f_ref(x2);
  assign eb2 = sel_b ? rnd_b[x2] : f_ref(x2);

  truth_table_sweeper #(.SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(exp1),
    .eval_a(ea1), .eval_b(eb1), .x(x1), .busy(busy1), .done(done1),
    .table_a(ta1), .table_b(tb1), .mismatch_a(ma1), .mismatch_b(mb1), .pass(pass1)
  );

  truth_table_sweeper #(.SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .expected(exp2),
    .eval_a(ea2), .eval_b(eb2), .x(x2), .busy(busy2), .done(done2),
    .table_a(ta2), .table_b(tb2), .mismatch_a(ma2), .mismatch_b(mb2), .pass(pass2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_idle_zero1(input string tag);
    check_eq({tag, "_x"}, 32'(x1), 0);
    check_eq({tag, "_busy"}, 32'(busy1), 0);
    check_eq({tag, "_done"}, 32'(done1), 0);
    check_eq({tag, "_ta"}, 32'(ta1), 0);
    check_eq({tag, "_tb"}, 32'(tb1), 0);
    check_eq({tag, "_ma"}, 32'(ma1), 0);
    check_eq({tag, "_mb"}, 32'(mb1), 0);
    check_eq({tag, "_pass"}, 32'(pass1), 0);
  endtask

  // SETTLE=2 sweep(s); entered and left at #1 after a rising edge with dut1 idle.
  // Vector i is sampled on edge T0 + 3i + 3, so x = k/3 after edge T0+k.
  task automatic sweep1(input logic [15:0] expv, input int restart_at,
                        input bit hold, input int nsw);
    logic [15:0] wa, wb;
    wa = ref_table(sel_a, rnd_a);
    wb = ref_table(sel_b, rnd_b);
    exp1 = expv;
    start1 = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < nsw; s++) begin
      check_eq("start_ta_clr", 32'(ta1), 0);
      check_eq("start_tb_clr", 32'(tb1), 0);
      check_eq("start_pass_clr", 32'(pass1), 0);
      for (int k = 0; k < 48; k++) begin
        check_eq("busy", 32'(busy1), 1);
        check_eq("done_early", 32'(done1), 0);
        check_eq("x_seq", 32'(x1), (k / 3 > 15) ? 15 : k / 3);
        start1 = (hold && s == 0) || (k == restart_at);
        @(posedge clk); #1;
      end
      check_eq("done", 32'(done1), 1);
      check_eq("busy_end", 32'(busy1), 0);
      check_eq("x_end", 32'(x1), 15);
      check_eq("table_a", 32'(ta1), 32'(wa));
      check_eq("table_b", 32'(tb1), 32'(wb));
      check_eq("mismatch_a", 32'(ma1), 32'(wa ^ expv));
      check_eq("mismatch_b", 32'(mb1), 32'(wb ^ expv));
      check_eq("pass", 32'(pass1), 32'(((wa ^ expv) == 0) && ((wb ^ expv) == 0)));
      start1 = (s + 1 < nsw);
      @(posedge clk); #1;
      if (s + 1 < nsw) begin
        check_eq("restart_x", 32'(x1), 0);
        start1 = 1'b0;
      end else begin
        check_eq("done_once", 32'(done1), 0);
        check_eq("idle_busy", 32'(busy1), 0);
        check_eq("hold_table_a", 32'(ta1), 32'(wa));
        check_eq("hold_pass", 32'(pass1), 32'(((wa ^ expv) == 0) && ((wb ^ expv) == 0)));
      end
    end
  endtask

  // SETTLE=1 sweep aborted by abort sampled on edge T0+d (1 <= d <= 32).
  task automatic abort2_test(input int d, input logic [15:0] expv, input bit with_start);
    logic [15:0] wa, wb, mask;
    int n;
    wa = ref_table(sel_a, rnd_a);
    wb = ref_table(sel_b, rnd_b);
    exp2 = expv;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 0; k < d; k++) begin
      check_eq("ab_busy", 32'(busy2), 1);
      if (k == d - 1) begin
        abort2 = 1'b1;
        start2 = with_start;
      end
      @(posedge clk); #1;
    end
    abort2 = 1'b0;
    start2 = 1'b0;
    n = (d - 1) / 2;
    mask = 16'((32'd1 << n) - 1);
    check_eq("ab_busy_off", 32'(busy2), 0);
    check_eq("ab_x_hold", 32'(x2), 32'(n));
    check_eq("ab_table_a", 32'(ta2), 32'(wa & mask));
    check_eq("ab_table_b", 32'(tb2), 32'(wb & mask));
    check_eq("ab_ma", 32'(ma2), 0);
    check_eq("ab_mb", 32'(mb2), 0);
    for (int k = 0; k < 3; k++) begin
      check_eq("ab_no_done", 32'(done2), 0);
      check_eq("ab_pass", 32'(pass2), 0);
      check_eq("ab_idle", 32'(busy2), 0);
      @(posedge clk); #1;
    end
    check_eq("ab_table_keep", 32'(ta2), 32'(wa & mask));
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; exp1 = '0;
    start2 = 1'b0; abort2 = 1'b0; exp2 = '0;
    sel_a = 1'b0; sel_b = 1'b0; rnd_a = '0; rnd_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero1("reset");
    check_eq("reset2_busy", 32'(busy2), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both implementations correct
    sweep1(F_SOP, -1, 1'b0, 1);
    // Implementation B stuck at 0
    sel_b = 1'b1; rnd_b = '0;
    sweep1(F_SOP, -1, 1'b0, 1);
    sel_b = 1'b0;
    // Start re-pulsed mid-sweep is ignored
    sweep1(F_SOP, 20, 1'b0, 1);
    // Start held high straight through DONE
    sweep1(F_SOP, -1, 1'b1, 2);

    // Asynchronous reset at x=7
    exp1 = F_SOP;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check_eq("pre_rst_x", 32'(x1), 7);
    check_eq("pre_rst_ta", 32'(ta1), 32'(ref_table(1'b0, '0) & 16'h007F));
    #2 rst = 1'b1;
    #1;
    check_idle_zero1("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    sweep1(F_SOP, -1, 1'b0, 1);

    // Abort on the SETTLE=1 instance: ten cycles into the sweep, then randomized
    abort2_test(11, F_SOP, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sel_a = 1'($urandom_range(0, 1)); rnd_a = 16'($urandom);
      sel_b = 1'($urandom_range(0, 1)); rnd_b = 16'($urandom);
      abort2_test(int'($urandom_range(1, 32)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Randomized sweeps on the SETTLE=2 instance
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ev;
      int ra;
      bit hd;
      sel_a = 1'($urandom_range(0, 1)); rnd_a = 16'($urandom);
      sel_b = 1'($urandom_range(0, 1)); rnd_b = 16'($urandom);
      ev = ($urandom_range(0, 1) == 1) ? F_SOP : 16'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 47)) : -1;
      hd = 1'($urandom_range(0, 1));
      sweep1(ev, ra, hd, hd ? 2 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
